// File: rtl/tube_readout_ctrl_if.sv
// ---------------------------------------------------------------------------
// tube_readout_ctrl_if
//   Readout FIFO write port shared between the tube readout sequencer and the
//   event FIFO.
//
//   fifo_full   FIFO -> sequencer   FIFO cannot accept a word this cycle
//   fifo_din    sequencer -> FIFO   word presented for writing
//   fifo_wr_en  sequencer -> FIFO   word accepted on each rising clk edge where high
//
//   master: the sequencer (writer); slave: the FIFO (reader).
// ---------------------------------------------------------------------------
interface tube_readout_ctrl_if;
   logic       fifo_full;
   logic [7:0] fifo_din;
   logic       fifo_wr_en;

   modport master (
      input  fifo_full,
      output fifo_din,
      output fifo_wr_en
   );

   modport slave (
      output fifo_full,
      input  fifo_din,
      input  fifo_wr_en
   );
endinterface

// File: rtl/tube_readout_ctrl.sv
// ---------------------------------------------------------------------------
// tube_readout_ctrl
//   Event sequencer for the per-tube drift-time counter bank. On a rising
//   scintillator trigger it:
//   - opens the counter gate for GATE_CYCLES;
//   - waits SETTLE_CYCLES;
//   - streams a header word (event number) and one 8-bit count per tube into
//     the readout FIFO, stalling while the FIFO is full;
//   - clears the counters for one cycle, then holds them cleared for
//     HOLDOFF_CYCLES before re-arming.
//   Triggers seen while busy are dropped and counted.
//
// Ports
//   clk           system clock, rising edge
//   clr           asynchronous active-high reset
//   scin_trig     trigger level, synchronous to clk
//   tube_data     packed tube counts, tube i at [8i+7:8i]
//   fifo          readout FIFO write port (master side)
//   gate_en       gate enable to all tube counters
//   tube_clr      clear to all tube counters
//   busy          high whenever the sequencer is not idle
//   event_num     events completed since reset (wraps)
//   dropped_trig  triggers ignored while busy (saturates at 255)
// ---------------------------------------------------------------------------
module tube_readout_ctrl #(
   parameter int unsigned NUM_TUBES      = 8,
   parameter int unsigned GATE_CYCLES    = 255,
   parameter int unsigned SETTLE_CYCLES  = 2,
   parameter int unsigned HOLDOFF_CYCLES = 16
) (
   input  logic                   clk,
   input  logic                   clr,
   input  logic                   scin_trig,
   input  logic [8*NUM_TUBES-1:0] tube_data,
   tube_readout_ctrl_if.master    fifo,
   output logic                   gate_en,
   output logic                   tube_clr,
   output logic                   busy,
   output logic [7:0]             event_num,
   output logic [7:0]             dropped_trig
);

   localparam int unsigned IdxW = (NUM_TUBES > 1) ? $clog2(NUM_TUBES) : 1;

   // Counters are loaded with N-1 and the phase ends on the cycle they read 0,
   // so each phase lasts exactly N cycles.
   localparam logic [15:0]     GateLoad    = 16'(GATE_CYCLES - 1);
   localparam logic [15:0]     SettleLoad  = 16'(SETTLE_CYCLES - 1);
   localparam logic [15:0]     HoldoffLoad = 16'(HOLDOFF_CYCLES - 1);
   localparam logic [IdxW-1:0] LastIdx     = IdxW'(NUM_TUBES - 1);

   typedef enum logic [2:0] {
      StIdle,
      StGate,
      StSettle,
      StHeader,
      StRead,
      StClear,
      StHoldoff
   } state_e;

   state_e          state_q, state_d;
   logic [15:0]     cnt_q, cnt_d;
   logic [IdxW-1:0] idx_q, idx_d;
   logic [7:0]      event_num_q, event_num_d;
   logic [7:0]      dropped_q, dropped_d;
   logic            prev_trig_q;

   logic            trig_edge;
   logic            wr_phase;
   logic [7:0]      din;
   logic [7:0]      tube_word;

   assign trig_edge = scin_trig & ~prev_trig_q;

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         idx_q       <= '0;
         event_num_q <= '0;
         dropped_q   <= '0;
         // Reset to 1 so a trigger level held across reset is not an edge.
         prev_trig_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         event_num_q <= event_num_d;
         dropped_q   <= dropped_d;
         prev_trig_q <= scin_trig;
      end
   end

   // ------------------------------------------------------------------------
   // Tube count selected by the read index
   // ------------------------------------------------------------------------
   always_comb begin
      tube_word = '0;
      for (int i = 0; i < int'(NUM_TUBES); i++) begin
         if (idx_q == IdxW'(i)) begin
            tube_word = tube_data[8*i +: 8];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and outputs
   // ------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      event_num_d = event_num_q;
      gate_en     = 1'b0;
      tube_clr    = 1'b0;
      wr_phase    = 1'b0;
      din         = 8'h00;

      unique case (state_q)
         StIdle: begin
            tube_clr = 1'b1;
            if (trig_edge) begin
               state_d = StGate;
               cnt_d   = GateLoad;
            end
         end

         StGate: begin
            gate_en = 1'b1;
            if (cnt_q == '0) begin
               state_d = StSettle;
               cnt_d   = SettleLoad;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end

         StSettle: begin
            if (cnt_q == '0) begin
               state_d = StHeader;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end

         StHeader: begin
            wr_phase = 1'b1;
            din      = event_num_q;
            if (!fifo.fifo_full) begin
               state_d = StRead;
               idx_d   = '0;
            end
         end

         StRead: begin
            wr_phase = 1'b1;
            din      = tube_word;
            if (!fifo.fifo_full) begin
               if (idx_q == LastIdx) begin
                  state_d = StClear;
               end else begin
                  idx_d = idx_q + IdxW'(1);
               end
            end
         end

         StClear: begin
            tube_clr    = 1'b1;
            event_num_d = event_num_q + 8'd1;
            if (HOLDOFF_CYCLES == 0) begin
               state_d = StIdle;
            end else begin
               state_d = StHoldoff;
               cnt_d   = HoldoffLoad;
            end
         end

         StHoldoff: begin
            tube_clr = 1'b1;
            if (cnt_q == '0) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end

         default: begin
            tube_clr = 1'b1;
            state_d  = StIdle;
         end
      endcase
   end

   // Any trigger edge outside idle is ignored; count it, saturating.
   always_comb begin
      dropped_d = dropped_q;
      if (trig_edge && (state_q != StIdle) && (dropped_q != 8'hff)) begin
         dropped_d = dropped_q + 8'd1;
      end
   end

   assign fifo.fifo_din   = din;
   assign fifo.fifo_wr_en = wr_phase & ~fifo.fifo_full;
   assign busy            = (state_q != StIdle);
   assign event_num       = event_num_q;
   assign dropped_trig    = dropped_q;

   // Gate and clear must never fight over the counters.
   a_gate_clr_excl: assert property (@(posedge clk) disable iff (clr) !(gate_en && tube_clr));
   a_no_write_full: assert property (@(posedge clk) disable iff (clr)
                                     !(fifo.fifo_wr_en && fifo.fifo_full));

endmodule

// File: tb/tb_tube_readout_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tube_readout_ctrl
//   Self-checking bench for tube_readout_ctrl. A timeline model predicts each
//   cycle's outputs from the accepted trigger time, the number of words
//   written so far and the time of the last write.
// ---------------------------------------------------------------------------
module tb_tube_readout_ctrl;

   localparam int unsigned NT = 4;
   localparam int unsigned GC = 16;
   localparam int unsigned SC = 2;
   localparam int unsigned HC = 8;

   logic            clk = 1'b0;
   logic            clr = 1'b1;
   logic            scin_trig = 1'b0;
   logic [8*NT-1:0] tube_data = '0;
   logic            gate_en;
   logic            tube_clr;
   logic            busy;
   logic [7:0]      event_num;
   logic [7:0]      dropped_trig;

   tube_readout_ctrl_if fifo_bus ();

   tube_readout_ctrl #(
      .NUM_TUBES      (NT),
      .GATE_CYCLES    (GC),
      .SETTLE_CYCLES  (SC),
      .HOLDOFF_CYCLES (HC)
   ) dut (
      .clk          (clk),
      .clr          (clr),
      .scin_trig    (scin_trig),
      .tube_data    (tube_data),
      .fifo         (fifo_bus),
      .gate_en      (gate_en),
      .tube_clr     (tube_clr),
      .busy         (busy),
      .event_num    (event_num),
      .dropped_trig (dropped_trig)
   );

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
      $fatal(1);
   end

   int n_vec = 0;
   int n_err = 0;

   // Timeline model
   int cyc = 0;
   bit m_active = 0;
   int m_tacc = 0;    // cycle in which the accepted edge was sampled
   int m_wd = 0;      // words written for the current event
   int m_tlast = 0;   // cycle of the last word's write
   int m_ev = 0;
   int m_drop = 0;
   bit m_prev = 1;

   // Observations
   logic [7:0] wr_log[$];
   int         wr_cyc[$];
   int         gate_cnt = 0;
   int         fall_cyc = -1;
   bit         prev_busy_obs = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // 0 idle, 1 gate, 2 settle, 3 write, 4 clear, 5 holdoff
   function automatic int phase();
      int rel;
      if (!m_active) return 0;
      rel = cyc - m_tacc;
      if (rel <= int'(GC)) return 1;
      if (rel <= int'(GC + SC)) return 2;
      if (m_wd <= int'(NT)) return 3;
      if (cyc == m_tlast + 1) return 4;
      return 5;
   endfunction

   task automatic step(input bit trig, input bit full);
      int         ph;
      bit         edge_seen;
      logic [7:0] exp_din;
      @(negedge clk);
      scin_trig          = trig;
      fifo_bus.fifo_full = full;
      #1;
      ph = phase();
      if (m_wd == 0) exp_din = 8'(m_ev);
      else           exp_din = tube_data[8*(m_wd-1) +: 8];
      check_val("gate_en", gate_en, (ph == 1));
      check_val("tube_clr", tube_clr, (ph == 0 || ph == 4 || ph == 5));
      check_val("busy", busy, m_active);
      check_val("fifo_wr_en", fifo_bus.fifo_wr_en, (ph == 3 && !full));
      if (ph == 3) check_val("fifo_din", fifo_bus.fifo_din, exp_din);
      check_val("event_num", event_num, 32'(m_ev));
      check_val("dropped_trig", dropped_trig, 32'(m_drop));

      if (fifo_bus.fifo_wr_en) begin
         wr_log.push_back(fifo_bus.fifo_din);
         wr_cyc.push_back(cyc);
      end
      if (gate_en) gate_cnt++;
      if (prev_busy_obs && !busy) fall_cyc = cyc;
      prev_busy_obs = busy;

      // Advance the model across the coming rising edge
      edge_seen = trig && !m_prev;
      m_prev    = trig;
      if (ph == 3 && !full) begin
         m_wd++;
         if (m_wd == int'(NT) + 1) m_tlast = cyc;
      end
      if (ph == 4) m_ev = (m_ev + 1) % 256;
      if (m_active && m_wd == int'(NT) + 1 && cyc == m_tlast + 1 + int'(HC)) m_active = 0;
      if (edge_seen) begin
         if (ph != 0) begin
            if (m_drop < 255) m_drop++;
         end else begin
            m_active = 1;
            m_tacc   = cyc;
            m_wd     = 0;
         end
      end
      cyc++;
   endtask

   task automatic run_idle(input int maxc);
      int n = 0;
      do begin
         step(0, 0);
         n++;
      end while (m_active && n < maxc);
      if (m_active) check_val("run_idle_timeout", 32'(n), 32'(maxc + 1));
   endtask

   task automatic do_reset(input bit trig);
      @(negedge clk);
      #2;
      clr                = 1'b1;
      scin_trig          = trig;
      fifo_bus.fifo_full = 1'b0;
      #1;
      // Asynchronous response, before any clock edge
      check_val("rst_gate_en", gate_en, 0);
      check_val("rst_tube_clr", tube_clr, 1);
      check_val("rst_busy", busy, 0);
      check_val("rst_wr_en", fifo_bus.fifo_wr_en, 0);
      check_val("rst_event_num", event_num, 0);
      check_val("rst_dropped", dropped_trig, 0);
      @(negedge clk);
      clr      = 1'b0;
      m_active = 0;
      m_ev     = 0;
      m_drop   = 0;
      m_wd     = 0;
      // The edge before the next step samples trig with history 1: no edge.
      m_prev   = trig;
      prev_busy_obs = 0;
      cyc++;
   endtask

   initial begin
      int         t0;
      int         n;
      int         stalls;
      logic [7:0] exp_words[5];

      fifo_bus.fifo_full = 1'b0;
      do_reset(0);

      // clr mid-READ after two writes, trigger held across deassert
      tube_data = {8'h44, 8'h33, 8'h22, 8'h11};
      wr_log.delete();
      step(1, 0);
      n = 0;
      while (wr_log.size() < 2 && n < 100) begin
         step(0, 0);
         n++;
      end
      check_val("s5_two_writes", 32'(wr_log.size()), 2);
      do_reset(1);
      repeat (40) step(1, 0);
      check_val("s5_no_more_writes", 32'(wr_log.size()), 2);
      check_val("s5_event_num", event_num, 0);
      check_val("s5_busy", busy, 0);
      step(0, 0);

      // Single event, FIFO never full
      tube_data = {8'h40, 8'h30, 8'h20, 8'h10};
      wr_log.delete();
      wr_cyc.delete();
      gate_cnt = 0;
      fall_cyc = -1;
      t0 = cyc;
      step(1, 0);
      run_idle(100);
      step(0, 0);
      check_val("s1_gate_cycles", 32'(gate_cnt), 16);
      check_val("s1_words", 32'(wr_log.size()), 5);
      exp_words = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h40};
      for (int i = 0; i < 5; i++) begin
         if (i < wr_log.size()) check_val("s1_word", wr_log[i], exp_words[i]);
      end
      if (wr_cyc.size() == 5) begin
         check_val("s1_first_write_latency", 32'(wr_cyc[0] - t0), 19);
         // last word is accepted at the edge closing its cycle
         check_val("s1_busy_fall", 32'(fall_cyc - (wr_cyc[4] + 1)), 9);
      end
      check_val("s1_event_num", event_num, 1);

      // FIFO full for 5 cycles while tube1's count is presented
      tube_data = {8'hd4, 8'hc3, 8'hb2, 8'ha1};
      wr_log.delete();
      stalls = 0;
      step(1, 0);
      n = 0;
      while (m_active && n < 200) begin
         if (phase() == 3 && m_wd == 2 && stalls < 5) begin
            stalls++;
            step(0, 1);
         end else begin
            step(0, 0);
         end
         n++;
      end
      step(0, 0);
      check_val("s2_words", 32'(wr_log.size()), 5);
      exp_words = '{8'h01, 8'ha1, 8'hb2, 8'hc3, 8'hd4};
      for (int i = 0; i < 5; i++) begin
         if (i < wr_log.size()) check_val("s2_word", wr_log[i], exp_words[i]);
      end

      // Three extra edges during GATE and one in HOLDOFF
      wr_log.delete();
      step(1, 0);
      repeat (3) begin
         step(0, 0);
         step(1, 0);
      end
      step(0, 0);
      n = 0;
      while (phase() != 5 && n < 100) begin
         step(0, 0);
         n++;
      end
      step(1, 0);
      step(0, 0);
      run_idle(100);
      step(0, 0);
      check_val("s3_dropped", dropped_trig, 4);
      check_val("s3_words", 32'(wr_log.size()), 5);

      // 256 back-to-back events: headers 00..FF, event_num wraps
      do_reset(0);
      for (int e = 0; e < 256; e++) begin
         wr_log.delete();
         tube_data = {$urandom, $urandom};
         step(1, 0);
         run_idle(100);
         if (wr_log.size() > 0) check_val("s4_header", wr_log[0], 32'(e));
         else                   check_val("s4_no_header", 0, 1);
      end
      step(0, 0);
      check_val("s4_event_num_wrap", event_num, 0);

      // Random triggers and FIFO stalls; drops saturate
      for (int i = 0; i < 3000; i++) begin
         if (i % 50 == 0) tube_data = {$urandom, $urandom};
         step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      end
      run_idle(200);
      step(0, 0);
      check_val("s6_dropped_sat", dropped_trig, 255);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
